// File: rtl/if_id_stage_ctrl.sv
// Fetch-side pipeline control: PC register, IF/ID register, jal link capture,
// stall/flush counters and a stall watchdog.
module if_id_stage_ctrl #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_PC    = '0,
    parameter int                 STALL_LIMIT = 16,
    parameter int                 CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             PC_Write,
    input  logic             IF_ID_Write,
    input  logic             IF_Flush,
    input  logic             jal_Control,
    input  logic             redirect,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] Instr_IF,
    input  logic             Cnt_Clr,
    output logic [WIDTH-1:0] PC_IF,
    output logic [WIDTH-1:0] Instr_ID,
    output logic [WIDTH-1:0] PCPlus4_ID,
    output logic             Valid_ID,
    output logic [WIDTH-1:0] Link_PC,
    output logic             Link_Valid,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic             Deadlock
);

    localparam int LEN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [LEN_W-1:0] LIMIT   = LEN_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN,
        STALLED,
        HUNG
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] stall_len, stall_len_n;
    logic             dl_set;
    logic             stall;
    logic [WIDTH-1:0] pc_plus4;

    assign stall    = !PC_Write && !IF_ID_Write;
    assign pc_plus4 = PC_IF + WIDTH'(4);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PC_IF      <= RESET_PC;
            Instr_ID   <= '0;
            PCPlus4_ID <= '0;
            Valid_ID   <= 1'b0;
        end else begin
            if (PC_Write) begin
                PC_IF <= redirect ? branch_target : pc_plus4;
            end
            // A flush bubbles IF/ID even while IF/ID is otherwise held
            if (IF_Flush) begin
                Instr_ID   <= '0;
                PCPlus4_ID <= '0;
                Valid_ID   <= 1'b0;
            end else if (IF_ID_Write) begin
                Instr_ID   <= Instr_IF;
                PCPlus4_ID <= pc_plus4;
                Valid_ID   <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Link_PC    <= '0;
            Link_Valid <= 1'b0;
        end else begin
            Link_Valid <= jal_Control;
            if (jal_Control) begin
                Link_PC <= PCPlus4_ID;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
            Deadlock  <= 1'b0;
        end else if (Cnt_Clr) begin
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
            Deadlock  <= 1'b0;
        end else begin
            if (!PC_Write && Stall_Cnt != CNT_MAX) begin
                Stall_Cnt <= Stall_Cnt + 1'b1;
            end
            if (IF_Flush && Flush_Cnt != CNT_MAX) begin
                Flush_Cnt <= Flush_Cnt + 1'b1;
            end
            if (dl_set) begin
                Deadlock <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= RUN;
            stall_len <= '0;
        end else begin
            state     <= state_n;
            stall_len <= stall_len_n;
        end
    end

    always_comb begin
        state_n     = state;
        stall_len_n = stall_len;
        dl_set      = 1'b0;
        unique case (state)
            RUN: begin
                if (stall) begin
                    state_n     = STALLED;
                    stall_len_n = LEN_W'(1);
                end
            end
            STALLED: begin
                if (!stall) begin
                    state_n     = RUN;
                    stall_len_n = '0;
                end else begin
                    stall_len_n = stall_len + LEN_W'(1);
                    if (stall_len + LEN_W'(1) == LIMIT) begin
                        state_n = HUNG;
                        dl_set  = 1'b1;
                    end
                end
            end
            HUNG: begin
                // Stays hung without re-flagging until the stall breaks
                if (!stall) begin
                    state_n     = RUN;
                    stall_len_n = '0;
                end
            end
            default: begin
                state_n     = RUN;
                stall_len_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Bench for if_id_stage_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model.
module tb_if_id_stage_ctrl;

    localparam int W     = 32;
    localparam int LIMIT = 16;
    localparam int CW    = 4;
    localparam int VW    = 4 * W + 3 + 2 * CW;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          PC_Write, IF_ID_Write, IF_Flush, jal_Control;
    logic          redirect, Cnt_Clr;
    logic [W-1:0]  branch_target, Instr_IF;
    logic [W-1:0]  PC_IF, Instr_ID, PCPlus4_ID, Link_PC;
    logic          Valid_ID, Link_Valid, Deadlock;
    logic [CW-1:0] Stall_Cnt, Flush_Cnt;

    if_id_stage_ctrl #(
        .WIDTH(W), .RESET_PC('0), .STALL_LIMIT(LIMIT), .CNT_W(CW)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .IF_Flush(IF_Flush), .jal_Control(jal_Control),
        .redirect(redirect), .branch_target(branch_target),
        .Instr_IF(Instr_IF), .Cnt_Clr(Cnt_Clr),
        .PC_IF(PC_IF), .Instr_ID(Instr_ID), .PCPlus4_ID(PCPlus4_ID),
        .Valid_ID(Valid_ID), .Link_PC(Link_PC), .Link_Valid(Link_Valid),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt), .Deadlock(Deadlock)
    );

    always #5 Clk = ~Clk;

    int ncmp = 0;
    int nbad = 0;

    // reference model state
    logic [W-1:0] m_pc, m_ins, m_pc4, m_link;
    logic         m_v, m_lv, m_dl;
    int           m_scnt, m_fcnt, m_streak;

    function automatic logic [VW-1:0] dut_vec();
        return {PC_IF, Instr_ID, PCPlus4_ID, Valid_ID, Link_PC,
                Link_Valid, Stall_Cnt, Flush_Cnt, Deadlock};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        return {m_pc, m_ins, m_pc4, m_v, m_link, m_lv,
                CW'(m_scnt), CW'(m_fcnt), m_dl};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_ins = '0; m_pc4 = '0; m_link = '0;
        m_v = 0; m_lv = 0; m_dl = 0;
        m_scnt = 0; m_fcnt = 0; m_streak = 0;
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl,
                         input logic jal, input logic rd,
                         input logic [W-1:0] bt, input logic [W-1:0] ins,
                         input logic clr);
        PC_Write = pw; IF_ID_Write = iw; IF_Flush = fl; jal_Control = jal;
        redirect = rd; branch_target = bt; Instr_IF = ins; Cnt_Clr = clr;
    endtask

    // Apply the behavioural rules to the model, then let the DUT take the edge
    task automatic step();
        logic         stall;
        logic [W-1:0] old_pc4;
        stall   = !PC_Write && !IF_ID_Write;
        old_pc4 = m_pc4;
        if (IF_Flush) begin
            m_ins = '0; m_pc4 = '0; m_v = 0;
        end else if (IF_ID_Write) begin
            m_ins = Instr_IF; m_pc4 = m_pc + 32'd4; m_v = 1;
        end
        if (PC_Write) m_pc = redirect ? branch_target : m_pc + 32'd4;
        if (jal_Control) m_link = old_pc4;
        m_lv     = jal_Control;
        m_streak = stall ? m_streak + 1 : 0;
        if (Cnt_Clr) begin
            m_scnt = 0; m_fcnt = 0; m_dl = 0;
        end else begin
            if (!PC_Write) m_scnt = (m_scnt + 1 > 15) ? 15 : m_scnt + 1;
            if (IF_Flush)  m_fcnt = (m_fcnt + 1 > 15) ? 15 : m_fcnt + 1;
            if (m_streak == LIMIT) m_dl = 1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, 0);
        model_reset();
        #2;
        ncmp++;
        if (dut_vec() !== mdl_vec()) begin
            nbad++;
            $display("FAIL reset got %h want %h", dut_vec(), mdl_vec());
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_fetch();
        drive(1, 1, 0, 0, 0, '0, 32'h8C010004, 0);
        step();
        ncmp++;
        if ({PC_IF, Instr_ID, PCPlus4_ID, Valid_ID} !==
            {32'h4, 32'h8C010004, 32'h4, 1'b1}) begin
            nbad++;
            $display("FAIL fetch got pc=%h ins=%h p4=%h v=%b want 4 8c010004 4 1",
                     PC_IF, Instr_ID, PCPlus4_ID, Valid_ID);
        end
        drive(1, 1, 0, 0, 0, '0, 32'h00A00093, 0);
        step();
        ncmp++;
        if (dut_vec() !== mdl_vec()) begin
            nbad++;
            $display("FAIL fetch2 got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_stall();
        drive(0, 0, 0, 0, 0, '0, 32'hDEADBEEF, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            ncmp++;
            if ({PC_IF, Instr_ID, PCPlus4_ID} !== {32'h8, 32'h00A00093, 32'h8}) begin
                nbad++;
                $display("FAIL stall_hold got pc=%h ins=%h p4=%h want 8 00a00093 8",
                         PC_IF, Instr_ID, PCPlus4_ID);
            end
        end
        ncmp++;
        if (Stall_Cnt !== 4'd2) begin
            nbad++;
            $display("FAIL stall_cnt got %0d want 2", Stall_Cnt);
        end
        drive(1, 1, 0, 0, 0, '0, 32'h11111111, 0);
        step();
        ncmp++;
        if (PC_IF !== 32'hC) begin
            nbad++;
            $display("FAIL stall_release got %h want c", PC_IF);
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 1, 0, 1, 32'h40, 32'h22222222, 0);
        step();
        ncmp++;
        if ({PC_IF, Instr_ID, Valid_ID, Flush_Cnt} !== {32'h40, 32'h0, 1'b0, 4'd1}) begin
            nbad++;
            $display("FAIL flush got pc=%h ins=%h v=%b fc=%0d want 40 0 0 1",
                     PC_IF, Instr_ID, Valid_ID, Flush_Cnt);
        end
        // flush with IF/ID write disabled still bubbles; PC advances
        drive(1, 0, 1, 0, 0, '0, 32'h33333333, 0);
        step();
        ncmp++;
        if (dut_vec() !== mdl_vec()) begin
            nbad++;
            $display("FAIL flush_nowrite got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_jal();
        Reset_n = 1'b0;
        model_reset();
        #1;
        Reset_n = 1'b1;
        drive(1, 1, 0, 0, 0, '0, 32'h0000006F, 0);
        repeat (5) step();
        ncmp++;
        if (PCPlus4_ID !== 32'h14) begin
            nbad++;
            $display("FAIL jal_setup got %h want 14", PCPlus4_ID);
        end
        jal_Control = 1'b1;
        step();
        ncmp++;
        if ({Link_PC, Link_Valid} !== {32'h14, 1'b1}) begin
            nbad++;
            $display("FAIL jal_capture got %h/%b want 14/1", Link_PC, Link_Valid);
        end
        jal_Control = 1'b0;
        step();
        ncmp++;
        if ({Link_PC, Link_Valid} !== {32'h14, 1'b0}) begin
            nbad++;
            $display("FAIL jal_pulse got %h/%b want 14/0", Link_PC, Link_Valid);
        end
        // held for two cycles: two captures, two cycles of valid
        jal_Control = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            ncmp++;
            if (dut_vec() !== mdl_vec() || Link_Valid !== 1'b1) begin
                nbad++;
                $display("FAIL jal_hold got %h want %h", dut_vec(), mdl_vec());
            end
        end
        jal_Control = 1'b0;
        step();
        ncmp++;
        if (dut_vec() !== mdl_vec()) begin
            nbad++;
            $display("FAIL jal_end got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_deadlock();
        drive(0, 0, 0, 0, 0, '0, '0, 1);
        step();
        Cnt_Clr = 1'b0;
        drive(1, 1, 0, 0, 0, '0, 32'h1, 0);
        step();
        drive(0, 0, 0, 0, 0, '0, 32'h2, 0);
        repeat (LIMIT - 1) step();
        ncmp++;
        if (Deadlock !== 1'b0) begin
            nbad++;
            $display("FAIL deadlock_early got %b want 0", Deadlock);
        end
        step();
        ncmp++;
        if (Deadlock !== 1'b1) begin
            nbad++;
            $display("FAIL deadlock_set got %b want 1", Deadlock);
        end
        drive(1, 1, 0, 0, 0, '0, 32'h3, 0);
        step();
        ncmp++;
        if (Deadlock !== 1'b1) begin
            nbad++;
            $display("FAIL deadlock_sticky got %b want 1", Deadlock);
        end
        Cnt_Clr = 1'b1;
        step();
        Cnt_Clr = 1'b0;
        ncmp++;
        if ({Deadlock, Stall_Cnt} !== {1'b0, 4'd0}) begin
            nbad++;
            $display("FAIL deadlock_clr got %b/%0d want 0/0", Deadlock, Stall_Cnt);
        end
    endtask

    task automatic test_saturate();
        drive(0, 1, 0, 0, 0, '0, 32'h4, 0);
        repeat (20) step();
        ncmp++;
        if (Stall_Cnt !== 4'd15) begin
            nbad++;
            $display("FAIL stall_sat got %0d want 15", Stall_Cnt);
        end
        drive(0, 0, 0, 0, 0, '0, 32'h5, 0);
        repeat (3) step();
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        ncmp++;
        if (dut_vec() !== mdl_vec()) begin
            nbad++;
            $display("FAIL reset_midstall got %h want %h", dut_vec(), mdl_vec());
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic sb;
            sb = ($urandom_range(0, 9) < ((i / 100) % 2 == 1 ? 9 : 2));
            drive(sb ? 1'b0 : 1'($urandom), sb ? 1'b0 : 1'($urandom),
                  ($urandom_range(0, 5) == 0), 1'($urandom),
                  ($urandom_range(0, 3) == 0), $urandom, $urandom,
                  ($urandom_range(0, 40) == 0));
            step();
            ncmp++;
            if (dut_vec() !== mdl_vec()) begin
                nbad++;
                $display("FAIL random[%0d] got %h want %h", i, dut_vec(), mdl_vec());
            end
            if ($urandom_range(0, 60) == 0) begin
                #2;
                Reset_n = 1'b0;
                model_reset();
                #1;
                ncmp++;
                if (dut_vec() !== mdl_vec()) begin
                    nbad++;
                    $display("FAIL random_reset[%0d] got %h want %h",
                             i, dut_vec(), mdl_vec());
                end
                Reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_flush();
        test_jal();
        test_deadlock();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
